// File: rtl/music_sequencer.sv
// Note sequencer: steps through a registered song ROM and holds each note for a
// programmable number of cycles. It supports loop, one-shot, pause and stop.
module music_sequencer #(
  parameter int NOTE_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int SONG_LEN = 10,
  parameter int TEMPO_W  = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               loop_en,
  input  logic [TEMPO_W-1:0] tempo,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [NOTE_W-1:0]  rom_note,
  output logic [NOTE_W-1:0]  note,
  output logic               note_valid,
  output logic               playing,
  output logic               step_strobe,
  output logic               done
);

  // state | meaning
  // IDLE  | stopped, rom_addr=0, note=0, waiting for start
  // ADDR  | rom_addr presented, ROM samples it at the exiting edge
  // DATA  | ROM data valid, captured into note at the exiting edge
  // PLAY  | note held while the step timer counts down to zero
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_PLAY} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [TEMPO_W-1:0]  timer_q, timer_d;
  logic [TEMPO_W-1:0]  tempo_q, tempo_d;
  logic                step_strobe_q, step_strobe_d;
  logic                done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rom_addr_q    <= '0;
      note_q        <= '0;
      timer_q       <= '0;
      tempo_q       <= '0;
      step_strobe_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rom_addr_q    <= rom_addr_d;
      note_q        <= note_d;
      timer_q       <= timer_d;
      tempo_q       <= tempo_d;
      step_strobe_q <= step_strobe_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rom_addr_d    = rom_addr_q;
    note_d        = note_q;
    timer_d       = timer_q;
    tempo_d       = tempo_q;
    step_strobe_d = 1'b0;
    done_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        rom_addr_d = '0;
        note_d     = '0;
        timer_d    = '0;
        if (start && !stop) begin
          tempo_d = tempo;
          state_d = S_ADDR;
        end
      end
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        note_d        = rom_note;
        step_strobe_d = 1'b1;
        timer_d       = tempo_q;
        state_d       = S_PLAY;
      end
      S_PLAY: begin
        // Pause freezes the whole step, including the end-of-step decision.
        if (!pause) begin
          if (timer_q != '0) begin
            timer_d = timer_q - TEMPO_W'(1);
          end else if (rom_addr_q != LAST_ADDR) begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            state_d    = S_ADDR;
          end else if (loop_en) begin
            rom_addr_d = '0;
            state_d    = S_ADDR;
          end else begin
            rom_addr_d = '0;
            note_d     = '0;
            done_d     = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stop overrides everything else that could happen in the same cycle.
    if (stop && state_q != S_IDLE) begin
      state_d       = S_IDLE;
      rom_addr_d    = '0;
      note_d        = '0;
      timer_d       = '0;
      step_strobe_d = 1'b0;
      done_d        = 1'b0;
    end
  end

  always_comb begin
    playing     = (state_q != S_IDLE);
    note_valid  = playing && (note_q != '0);
    rom_addr    = rom_addr_q;
    note        = note_q;
    step_strobe = step_strobe_q;
    done        = done_q;
  end

endmodule
